// File: rtl/blc_pkg.sv
// Shared definitions for the black-level-correction pipeline.
package blc_pkg;

    typedef enum logic [1:0] {
        BLC_BYPASS    = 2'd0,
        BLC_SUB_CLAMP = 2'd1,
        BLC_ADD_SAT   = 2'd2,
        BLC_RESERVED  = 2'd3
    } blc_mode_e;

    localparam int SOF_BIT = 0;

endpackage

// File: rtl/blc_chan_alu.sv
// Combinational per-channel black-level arithmetic: bypass, subtract-and-clamp,
// or signed add with saturation to the unsigned pixel range.
module blc_chan_alu
    import blc_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] o,
    input  blc_mode_e             mode,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] PIX_MAX = {2'b00, {DATA_WIDTH{1'b1}}};

    logic signed [SW-1:0] sum;

    // Two guard bits hold any x + o without wrap, so the sign bit flags underflow.
    assign sum = $signed({2'b00, x}) + $signed({{2{o[DATA_WIDTH-1]}}, o});

    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
        y = x;
        case (mode)
            BLC_SUB_CLAMP: y = (x >= o) ? x - o : '0;
            BLC_ADD_SAT: begin
                if (sum[SW-1])
                    y = '0;
                else if (sum > PIX_MAX)
                    y = '1;
                else
                    y = sum[DATA_WIDTH-1:0];
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/blc_pipe.sv
// Two-stage black-level-correction pipeline with valid/ready backpressure and
// double-buffered per-channel offsets that switch over on start-of-frame beats.
module blc_pipe
    import blc_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_CH     = 3,
    parameter int AUX_WIDTH  = 36,
    parameter int CH_SEL_W   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         u_i_ready,
    output logic                         i_i_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [AUX_WIDTH-1:0]         aux_in,
    output logic                         i_r_ready,
    input  logic                         u_r_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [AUX_WIDTH-1:0]         aux_out,
    input  logic                         cfg_we,
    input  logic [CH_SEL_W-1:0]          cfg_ch,
    input  logic [DATA_WIDTH-1:0]        cfg_offset,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_mode_we,
    output logic [1:0]                   active_mode
);

    localparam int BW = NUM_CH * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] shadow_off [NUM_CH];
    logic [DATA_WIDTH-1:0] active_off [NUM_CH];
    blc_mode_e             shadow_mode;
    blc_mode_e             act_mode;

    logic                  s1_valid;
    logic [BW-1:0]         s1_data;
    logic [AUX_WIDTH-1:0]  s1_aux;
    logic [DATA_WIDTH-1:0] s1_off [NUM_CH];
    blc_mode_e             s1_mode;

    logic                  s2_valid;
    logic [BW-1:0]         s2_data;
    logic [AUX_WIDTH-1:0]  s2_aux;

    logic [BW-1:0]         alu_y;
    logic                  s2_load;
    logic                  s1_advance;
    logic                  in_fire;
    logic                  sof_fire;
    logic                  cfg_hit;

    assign s2_load    = !s2_valid || u_r_ready;
    assign s1_advance = s1_valid && s2_load;
    assign i_i_ready  = !s1_valid || s1_advance;
    assign in_fire    = u_i_ready && i_i_ready;
    assign sof_fire   = in_fire && aux_in[SOF_BIT];
    assign cfg_hit    = cfg_we && (int'(cfg_ch) < NUM_CH);

    // NOTE: non-blocking updates mean a SOF beat latches the shadow value from
    // before any same-cycle cfg write; the write lands in shadow only.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the offset register files are reset because their zero state is
            // architecturally visible through the arithmetic.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shadow_off[ch] <= '0;
                active_off[ch] <= '0;
            end
            shadow_mode <= BLC_BYPASS;
            act_mode    <= BLC_BYPASS;
        end else begin
            if (sof_fire) begin
                active_off <= shadow_off;
                act_mode   <= shadow_mode;
            end
            if (cfg_hit)
                shadow_off[cfg_ch] <= cfg_offset;
            if (cfg_mode_we)
                shadow_mode <= blc_mode_e'(cfg_mode);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            s1_valid <= 1'b0;
        else if (i_i_ready)
            s1_valid <= u_i_ready;
    end

    // S1 payload is qualified by s1_valid and needs no reset.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            s1_data <= data_in;
            s1_aux  <= aux_in;
            s1_off  <= aux_in[SOF_BIT] ? shadow_off : active_off;
            s1_mode <= aux_in[SOF_BIT] ? shadow_mode : act_mode;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_alu
        blc_chan_alu #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_alu (
            .x   (s1_data[ch*DATA_WIDTH +: DATA_WIDTH]),
            .o   (s1_off[ch]),
            .mode(s1_mode),
            .y   (alu_y[ch*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_aux   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= alu_y;
                s2_aux  <= s1_aux;
            end
        end
    end

    assign i_r_ready   = s2_valid;
    assign data_out    = s2_data;
    assign aux_out     = s2_aux;
    assign active_mode = act_mode;

endmodule

// File: tb/tb_blc_pipe.sv
// Self-checking bench for blc_pipe: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the correction rules.
module tb_blc_pipe;

    localparam int DW = 12;
    localparam int NC = 3;
    localparam int AW = 36;
    localparam int CW = 2;
    localparam int BW = NC * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          u_i_ready;
    logic          i_i_ready;
    logic [BW-1:0] data_in;
    logic [AW-1:0] aux_in;
    logic          i_r_ready;
    logic          u_r_ready;
    logic [BW-1:0] data_out;
    logic [AW-1:0] aux_out;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_offset;
    logic [1:0]    cfg_mode;
    logic          cfg_mode_we;
    logic [1:0]    active_mode;

    always #5 clock = ~clock;

    blc_pipe #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NC),
        .AUX_WIDTH (AW),
        .CH_SEL_W  (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .u_i_ready  (u_i_ready),
        .i_i_ready  (i_i_ready),
        .data_in    (data_in),
        .aux_in     (aux_in),
        .i_r_ready  (i_r_ready),
        .u_r_ready  (u_r_ready),
        .data_out   (data_out),
        .aux_out    (aux_out),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_offset (cfg_offset),
        .cfg_mode   (cfg_mode),
        .cfg_mode_we(cfg_mode_we),
        .active_mode(active_mode)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [AW-1:0] aux;
        int            age;
    } beat_t;

    beat_t q[$];
    int    m_shadow_off [NC];
    int    m_active_off [NC];
    int    m_shadow_mode;
    int    m_active_mode;
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    last_in_fire;
    bit    last_iready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pix(input int x, input int o, input int mode);
        int so;
        int s;
        case (mode)
            1: return (x >= o) ? x - o : 0;
            2: begin
                so = (o >= (1 << (DW - 1))) ? o - (1 << DW) : o;
                s  = x + so;
                if (s < 0) return 0;
                if (s > (1 << DW) - 1) return (1 << DW) - 1;
                return s;
            end
            default: return x;
        endcase
    endfunction

    function automatic logic [BW-1:0] ref_beat(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = '0;
        for (int ch = 0; ch < NC; ch++)
            r[ch*DW +: DW] = DW'(ref_pix(int'(d[ch*DW +: DW]), m_active_off[ch], m_active_mode));
        return r;
    endfunction

    function automatic logic [BW-1:0] pack(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [AW-1:0] rand_aux(input bit sof);
        logic [AW-1:0] a;
        a    = AW'({$urandom(), $urandom()});
        a[0] = sof;
        return a;
    endfunction

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic step();
        bit exp_valid;
        bit exp_iready;
        bit out_fire;
        #1;
        exp_valid  = (q.size() > 0) && (q[0].age >= 2);
        exp_iready = !((q.size() == 2) && !u_r_ready);
        if (!reset) begin
            check("i_r_ready", i_r_ready, exp_valid);
            check("i_i_ready", i_i_ready, exp_iready);
            check("active_mode", active_mode, m_active_mode);
            if (exp_valid) begin
                check("data_out", data_out, q[0].data);
                check("aux_out", aux_out, q[0].aux);
            end
        end
        last_in_fire = !reset && u_i_ready && exp_iready;
        last_iready  = i_i_ready;
        out_fire     = !reset && exp_valid && u_r_ready;
        @(posedge clock);
        if (reset) begin
            q.delete();
            for (int ch = 0; ch < NC; ch++) begin
                m_shadow_off[ch] = 0;
                m_active_off[ch] = 0;
            end
            m_shadow_mode = 0;
            m_active_mode = 0;
        end else begin
            if (out_fire) void'(q.pop_front());
            if (last_in_fire) begin
                if (aux_in[0]) begin
                    m_active_off  = m_shadow_off;
                    m_active_mode = m_shadow_mode;
                end
                q.push_back('{data: ref_beat(data_in), aux: aux_in, age: 0});
            end
            if (cfg_we && int'(cfg_ch) < NC) m_shadow_off[cfg_ch] = int'(cfg_offset);
            if (cfg_mode_we) m_shadow_mode = int'(cfg_mode);
            foreach (q[i]) q[i].age = q[i].age + 1;
        end
        @(negedge clock);
    endtask

    task automatic send(input logic [BW-1:0] d, input bit sof);
        u_i_ready = 1'b1;
        data_in   = d;
        aux_in    = rand_aux(sof);
        for (int k = 0; k < 30; k++) begin
            step();
            if (last_in_fire) break;
        end
        check("send_accept", last_in_fire, 1'b1);
        u_i_ready = 1'b0;
    endtask

    task automatic drain();
        u_i_ready   = 1'b0;
        cfg_we      = 1'b0;
        cfg_mode_we = 1'b0;
        u_r_ready   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            step();
        end
        check("drain_empty", q.size(), 0);
    endtask

    // Stall the output until the head beat is presented, then compare it to a constant.
    task automatic expect_head(input string tag, input logic [BW-1:0] exp);
        u_r_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (i_r_ready) break;
            step();
        end
        check({tag, "_valid"}, i_r_ready, 1'b1);
        check(tag, data_out, exp);
    endtask

    task automatic pop_one();
        u_r_ready = 1'b1;
        step();
        u_r_ready = 1'b0;
    endtask

    task automatic write_off(input int ch, input int val);
        cfg_we     = 1'b1;
        cfg_ch     = CW'(ch);
        cfg_offset = DW'(val);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic write_mode(input int mode);
        cfg_mode_we = 1'b1;
        cfg_mode    = 2'(mode);
        step();
        cfg_mode_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  sent;
        bit  seen_block;
        logic [BW-1:0] stall_beats [6];

        reset       = 1'b1;
        u_i_ready   = 1'b0;
        u_r_ready   = 1'b1;
        data_in     = '0;
        aux_in      = '0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_offset  = '0;
        cfg_mode    = '0;
        cfg_mode_we = 1'b0;
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        check("reset_i_r_ready", i_r_ready, 1'b0);
        check("reset_data_out", data_out, '0);
        check("reset_aux_out", aux_out, '0);
        check("reset_active_mode", active_mode, 2'd0);
        check("reset_i_i_ready", i_i_ready, 1'b1);

        // Bypass streaming, back to back.
        u_r_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_i_ready = 1'b1;
            data_in   = BW'({$urandom(), $urandom()});
            aux_in    = rand_aux(1'b0);
            step();
        end
        drain();

        // SUB_CLAMP on an SOF beat.
        for (int ch = 0; ch < NC; ch++) write_off(ch, 64);
        write_mode(1);
        u_r_ready = 1'b0;
        send(pack(100, 64, 10), 1'b1);
        expect_head("sub_clamp", pack(36, 0, 0));
        drain();

        // ADD_SAT with negative and positive offsets.
        write_off(0, 12'hF00);
        write_off(1, 200);
        write_off(2, 12'hF00);
        write_mode(2);
        u_r_ready = 1'b0;
        send(pack(4000, 4000, 100), 1'b1);
        send(pack(100, 100, 4000), 1'b0);
        expect_head("add_sat_a", pack(3744, 4095, 0));
        pop_one();
        expect_head("add_sat_b", pack(0, 300, 3744));
        drain();

        // Stall mid-stream of six beats.
        for (int i = 0; i < 6; i++) stall_beats[i] = BW'({$urandom(), $urandom()});
        sent       = 0;
        seen_block = 1'b0;
        for (int c = 0; c < 40 && sent < 6; c++) begin
            u_i_ready = 1'b1;
            data_in   = stall_beats[sent];
            aux_in    = rand_aux(1'b0);
            u_r_ready = !(c >= 3 && c < 8);
            step();
            if (!last_iready) seen_block = 1'b1;
            if (last_in_fire) sent++;
        end
        check("stall_sent_all", sent, 6);
        check("stall_ready_dropped", seen_block, 1'b1);
        drain();

        // Shadow offsets only apply at SOF; same-cycle write lands in shadow only.
        write_off(0, 50);
        u_r_ready = 1'b0;
        send(pack(1000, 1000, 1000), 1'b0);
        expect_head("persist_old", pack(744, 1200, 744));
        drain();
        u_r_ready = 1'b0;
        send(pack(1000, 1000, 1000), 1'b1);
        expect_head("sof_new", pack(1050, 1200, 744));
        drain();
        cfg_we     = 1'b1;
        cfg_ch     = 2'd0;
        cfg_offset = 12'd7;
        u_r_ready  = 1'b0;
        send(pack(1000, 1000, 1000), 1'b1);
        cfg_we = 1'b0;
        expect_head("sof_same_cycle", pack(1050, 1200, 744));
        drain();
        write_off(3, 12'h123);
        u_r_ready = 1'b0;
        send(pack(1000, 1000, 1000), 1'b1);
        expect_head("sof_after", pack(1007, 1200, 744));
        drain();

        // Randomized traffic and configuration.
        for (int c = 0; c < 400; c++) begin
            u_i_ready   = ($urandom_range(0, 3) != 0);
            data_in     = BW'({$urandom(), $urandom()});
            aux_in      = rand_aux($urandom_range(0, 7) == 0);
            u_r_ready   = ($urandom_range(0, 3) != 0);
            cfg_we      = ($urandom_range(0, 3) == 0);
            cfg_ch      = CW'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cfg_offset = '0;
                1:       cfg_offset = '1;
                2:       cfg_offset = 12'h800;
                default: cfg_offset = DW'($urandom());
            endcase
            cfg_mode_we = ($urandom_range(0, 7) == 0);
            cfg_mode    = 2'($urandom_range(0, 3));
            step();
        end
        drain();

        // Reset in the middle of a stall with two beats in flight.
        write_mode(1);
        u_r_ready = 1'b0;
        send(BW'({$urandom(), $urandom()}), 1'b1);
        send(BW'({$urandom(), $urandom()}), 1'b0);
        step();
        step();
        check("pre_reset_active_mode", active_mode, 2'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_i_r_ready", i_r_ready, 1'b0);
        check("midrst_data_out", data_out, '0);
        check("midrst_aux_out", aux_out, '0);
        check("midrst_active_mode", active_mode, 2'd0);
        check("midrst_i_i_ready", i_i_ready, 1'b1);
        u_r_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        send(pack(123, 456, 789), 1'b1);
        expect_head("post_reset_bypass", pack(123, 456, 789));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
